// File: rtl/liteic_pkg.sv
// liteic_pkg: bus widths and response codes shared by the liteic AXI-lite blocks.
//   AXI_ADDR_WIDTH / AXI_DATA_WIDTH / AXI_STRB_WIDTH / AXI_RESP_WIDTH : channel widths
//   AXI_RESP_OKAY / AXI_RESP_SLVERR                                  : response encodings
package liteic_pkg;

  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int unsigned AXI_RESP_WIDTH = 2;

  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_SLVERR = 2'b10;

  typedef logic [AXI_ADDR_WIDTH-1:0] axi_addr_t;
  typedef logic [AXI_DATA_WIDTH-1:0] axi_data_t;
  typedef logic [AXI_STRB_WIDTH-1:0] axi_strb_t;
  typedef logic [AXI_RESP_WIDTH-1:0] axi_resp_t;

endpackage

// File: rtl/liteic_axil_responder_if.sv
// liteic_axil_responder_if: AXI-lite channel bundle between a liteic master slot and a
// responder. Signal names are given from the responder's point of view (_i = into responder).
//   master modport : drives AW/W/AR payload+valid and B/R ready
//   slave modport  : drives AW/W/AR ready and B/R payload+valid
interface liteic_axil_responder_if;
  import liteic_pkg::*;

  axi_addr_t  aw_addr_i;
  logic       aw_valid_i;
  logic [3:0] aw_qos_i;
  logic       aw_ready_o;

  axi_data_t  w_data_i;
  axi_strb_t  w_strb_i;
  logic       w_valid_i;
  logic       w_ready_o;

  axi_resp_t  b_resp_o;
  logic       b_valid_o;
  logic       b_ready_i;

  axi_addr_t  ar_addr_i;
  logic       ar_valid_i;
  logic [3:0] ar_qos_i;
  logic       ar_ready_o;

  axi_data_t  r_data_o;
  axi_resp_t  r_resp_o;
  logic       r_valid_o;
  logic       r_ready_i;

  modport master (
    output aw_addr_i, aw_valid_i, aw_qos_i, input aw_ready_o,
    output w_data_i, w_strb_i, w_valid_i, input w_ready_o,
    input b_resp_o, b_valid_o, output b_ready_i,
    output ar_addr_i, ar_valid_i, ar_qos_i, input ar_ready_o,
    input r_data_o, r_resp_o, r_valid_o, output r_ready_i
  );

  modport slave (
    input aw_addr_i, aw_valid_i, aw_qos_i, output aw_ready_o,
    input w_data_i, w_strb_i, w_valid_i, output w_ready_o,
    output b_resp_o, b_valid_o, input b_ready_i,
    input ar_addr_i, ar_valid_i, ar_qos_i, output ar_ready_o,
    output r_data_o, r_resp_o, r_valid_o, input r_ready_i
  );

endinterface

// File: rtl/liteic_lfsr_stall.sv
// liteic_lfsr_stall: pseudo-random stall generator used to throttle the responder's
// ready outputs. 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle.
//   clk_i   : clock
//   rstn_i  : asynchronous active-low reset (LFSR loads SEED)
//   o_stall : high on cycles where the ready outputs must be withheld
module liteic_lfsr_stall #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk_i,
  input  logic rstn_i,
  output logic o_stall
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  // Right-shifting form: tap n maps to bit (16 - n).
  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
    end
  end

  assign o_stall = r_lfsr[0];

endmodule

// File: rtl/liteic_axil_responder.sv
// liteic_axil_responder: AXI-lite slave endpoint terminating reads and writes into a local
// word-addressed memory of MEM_DEPTH words starting at byte address BASE_ADDR. Accesses
// outside the window return SLVERR (reads return zero data). Read and write paths are
// independent, each with one outstanding transaction.
//   clk_i  : clock
//   rstn_i : asynchronous active-low reset
//   bus    : AXI-lite channels (slave modport of liteic_axil_responder_if)
// Optional build macro LITEIC_RESP_STALL_EN: adds an LFSR that randomly withholds the
// AW/W/AR ready outputs; B/R valids are never gated.
module liteic_axil_responder
  import liteic_pkg::*;
#(
  parameter axi_addr_t   BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input logic                    clk_i,
  input logic                    rstn_i,
  liteic_axil_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned OFF_W = $clog2(AXI_STRB_WIDTH);
  // Window bounds compared one bit wider so a window touching the top of the map can't wrap.
  localparam int unsigned CMP_W = AXI_ADDR_WIDTH + 1;
  localparam logic [CMP_W-1:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [CMP_W-1:0] WIN_HI = WIN_LO + CMP_W'(MEM_DEPTH * AXI_STRB_WIDTH);

  // Write-side holding registers and B channel
  logic       r_aw_full;
  axi_addr_t  r_aw_addr;
  logic       r_w_full;
  axi_data_t  r_w_data;
  axi_strb_t  r_w_strb;
  logic       r_b_valid;
  axi_resp_t  r_b_resp;

  // R channel
  logic       r_r_valid;
  axi_data_t  r_r_data;
  axi_resp_t  r_r_resp;

  axi_data_t  r_mem [MEM_DEPTH];

  logic       w_stall;
  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_ar_hs;
  logic       w_commit;
  axi_addr_t  w_aw_off;
  axi_addr_t  w_ar_off;
  logic       w_aw_in_range;
  logic       w_ar_in_range;
  logic [IDX_W-1:0] w_aw_idx;
  logic [IDX_W-1:0] w_ar_idx;

`ifdef LITEIC_RESP_STALL_EN
  liteic_lfsr_stall #(
    .SEED (STALL_SEED)
  ) u_lfsr_stall (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .o_stall (w_stall)
  );
`else
  assign w_stall = 1'b0;
  logic unused_seed;
  assign unused_seed = ^STALL_SEED;
`endif

  // Address decode; low byte-offset bits and bits above the index are dropped.
  assign w_aw_in_range = ({1'b0, r_aw_addr} >= WIN_LO) && ({1'b0, r_aw_addr} < WIN_HI);
  assign w_ar_in_range = ({1'b0, bus.ar_addr_i} >= WIN_LO) && ({1'b0, bus.ar_addr_i} < WIN_HI);
  assign w_aw_off      = r_aw_addr - BASE_ADDR;
  assign w_ar_off      = bus.ar_addr_i - BASE_ADDR;
  assign w_aw_idx      = w_aw_off[OFF_W +: IDX_W];
  assign w_ar_idx      = w_ar_off[OFF_W +: IDX_W];

  logic unused_bits;
  assign unused_bits = ^{w_aw_off, w_ar_off, bus.aw_qos_i, bus.ar_qos_i};

  // Readies are purely combinational from state, so they sit at 1 through reset.
  assign bus.aw_ready_o = !r_aw_full && !w_stall;
  assign bus.w_ready_o  = !r_w_full && !w_stall;
  assign bus.ar_ready_o = (!r_r_valid || bus.r_ready_i) && !w_stall;

  assign w_aw_hs  = bus.aw_valid_i && bus.aw_ready_o;
  assign w_w_hs   = bus.w_valid_i && bus.w_ready_o;
  assign w_ar_hs  = bus.ar_valid_i && bus.ar_ready_o;
  // A commit may overlap the B handshake, letting back-to-back responses stay valid.
  assign w_commit = r_aw_full && r_w_full && (!r_b_valid || bus.b_ready_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_b_valid <= 1'b0;
      r_b_resp  <= '0;
    end else begin
      // Capture and commit are mutually exclusive: capture needs an empty slot,
      // commit needs a full one.
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= bus.aw_addr_i;
      end else if (w_commit) begin
        r_aw_full <= 1'b0;
      end

      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= bus.w_data_i;
        r_w_strb <= bus.w_strb_i;
      end else if (w_commit) begin
        r_w_full <= 1'b0;
      end

      if (w_commit) begin
        r_b_valid <= 1'b1;
        r_b_resp  <= w_aw_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end else if (bus.b_ready_i) begin
        r_b_valid <= 1'b0;
      end
    end
  end

  // Memory contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (w_commit && w_aw_in_range) begin
      for (int b = 0; b < int'(AXI_STRB_WIDTH); b++) begin
        if (r_w_strb[b]) begin
          r_mem[w_aw_idx][8*b +: 8] <= r_w_data[8*b +: 8];
        end
      end
    end
  end

  // Non-blocking read of r_mem gives read-before-write on a same-edge collision.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_r_valid <= 1'b0;
      r_r_data  <= '0;
      r_r_resp  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_r_valid <= 1'b1;
        r_r_data  <= w_ar_in_range ? r_mem[w_ar_idx] : '0;
        r_r_resp  <= w_ar_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end else if (bus.r_ready_i) begin
        r_r_valid <= 1'b0;
      end
    end
  end

  assign bus.b_valid_o = r_b_valid;
  assign bus.b_resp_o  = r_b_resp;
  assign bus.r_valid_o = r_r_valid;
  assign bus.r_data_o  = r_r_data;
  assign bus.r_resp_o  = r_r_resp;

endmodule
